// File: rtl/jtag_cmd_driver.sv
// rtl/jtag_cmd_driver.sv - JTAG command sequencer: RESET/IR/DR/IDLE commands to TMS/TDI, TDO capture
// Parks the TAP in Run-Test/Idle between commands; DONE is the idle-equivalent completion cycle.
module jtag_cmd_driver #(
  parameter int MAX_LEN = 32,
  parameter int LEN_W   = 6
) (
  input  logic               TCK,
  input  logic               TRST,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [1:0]         cmd_type,
  input  logic [LEN_W-1:0]   cmd_len,
  input  logic [MAX_LEN-1:0] cmd_data,
  output logic               TMS,
  output logic               TDI,
  input  logic               TDO,
  output logic               rsp_valid,
  output logic [MAX_LEN-1:0] rsp_data,
  output logic               rsp_err
);

  typedef enum logic [2:0] {
    S_INIT, S_IDLE, S_PRE, S_SHIFT, S_POST, S_WAIT, S_DONE
  } state_e;

  localparam logic [1:0] T_RESET = 2'd0;
  localparam logic [1:0] T_IR    = 2'd1;
  localparam logic [1:0] T_DR    = 2'd2;

  state_e             state_q, state_d;
  logic [LEN_W-1:0]   cnt_q, cnt_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic [1:0]         type_q, type_d;
  logic [MAX_LEN-1:0] sh_q, sh_d;
  logic [MAX_LEN-1:0] cap_q, cap_d;
  logic [MAX_LEN-1:0] rsp_data_q, rsp_data_d;
  logic               rsp_err_q, rsp_err_d;
  logic               len_bad;
  logic               last_cnt;

  assign len_bad  = (cmd_len == '0) || (cmd_len > LEN_W'(MAX_LEN));
  assign last_cnt = (cnt_q == len_q - LEN_W'(1));
  assign rsp_data = rsp_data_q;
  assign rsp_err  = rsp_err_q;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    len_d      = len_q;
    type_d     = type_q;
    sh_d       = sh_q;
    cap_d      = cap_q;
    rsp_data_d = rsp_data_q;
    rsp_err_d  = rsp_err_q;
    TMS        = 1'b0;
    TDI        = 1'b0;
    cmd_ready  = 1'b0;
    rsp_valid  = 1'b0;
    case (state_q)
      S_INIT: begin
        TMS = (cnt_q != LEN_W'(5));
        if (cnt_q == LEN_W'(5)) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + LEN_W'(1);
        end
      end
      S_IDLE, S_DONE: begin
        cmd_ready = 1'b1;
        rsp_valid = (state_q == S_DONE);
        state_d   = S_IDLE;
        if (cmd_valid) begin
          type_d = cmd_type;
          len_d  = cmd_len;
          sh_d   = cmd_data;
          cap_d  = '0;
          cnt_d  = '0;
          case (cmd_type)
            T_RESET: state_d = S_PRE;
            T_IR, T_DR: begin
              // Illegal scan lengths complete at once without touching TMS.
              if (len_bad) begin
                state_d    = S_DONE;
                rsp_data_d = '0;
                rsp_err_d  = 1'b1;
              end else begin
                state_d = S_PRE;
              end
            end
            default: begin
              if (cmd_len == '0) begin
                state_d    = S_DONE;
                rsp_data_d = '0;
                rsp_err_d  = 1'b0;
              end else begin
                state_d = S_WAIT;
              end
            end
          endcase
        end
      end
      S_PRE: begin
        cnt_d = cnt_q + LEN_W'(1);
        case (type_q)
          T_RESET: begin
            TMS = (cnt_q != LEN_W'(5));
            if (cnt_q == LEN_W'(5)) begin
              state_d    = S_DONE;
              rsp_data_d = '0;
              rsp_err_d  = 1'b0;
            end
          end
          T_IR: begin
            TMS = (cnt_q < LEN_W'(2));
            if (cnt_q == LEN_W'(3)) begin
              state_d = S_SHIFT;
              cnt_d   = '0;
            end
          end
          default: begin
            TMS = (cnt_q == '0);
            if (cnt_q == LEN_W'(2)) begin
              state_d = S_SHIFT;
              cnt_d   = '0;
            end
          end
        endcase
      end
      S_SHIFT: begin
        // The TAP presents TDO for bit i during the cycle the driver launches bit i.
        TDI   = sh_q[0];
        TMS   = last_cnt;
        sh_d  = sh_q >> 1;
        cap_d = cap_q | (MAX_LEN'(TDO) << cnt_q);
        cnt_d = cnt_q + LEN_W'(1);
        if (last_cnt) begin
          state_d = S_POST;
          cnt_d   = '0;
        end
      end
      S_POST: begin
        TMS   = (cnt_q == '0);
        cnt_d = cnt_q + LEN_W'(1);
        if (cnt_q == LEN_W'(1)) begin
          state_d    = S_DONE;
          rsp_data_d = cap_q;
          rsp_err_d  = 1'b0;
        end
      end
      S_WAIT: begin
        cnt_d = cnt_q + LEN_W'(1);
        if (last_cnt) begin
          state_d    = S_DONE;
          rsp_data_d = '0;
          rsp_err_d  = 1'b0;
        end
      end
      default: state_d = S_INIT;
    endcase
  end

  always_ff @(posedge TCK) begin
    if (TRST) begin
      state_q    <= S_INIT;
      cnt_q      <= '0;
      len_q      <= '0;
      type_q     <= '0;
      sh_q       <= '0;
      cap_q      <= '0;
      rsp_data_q <= '0;
      rsp_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      len_q      <= len_d;
      type_q     <= type_d;
      sh_q       <= sh_d;
      cap_q      <= cap_d;
      rsp_data_q <= rsp_data_d;
      rsp_err_q  <= rsp_err_d;
    end
  end

endmodule

// File: tb/tb_jtag_cmd_driver.sv
// tb/tb_jtag_cmd_driver.sv - scoreboard bench for jtag_cmd_driver with a behavioural TAP model
module tb_jtag_cmd_driver;
  localparam int MAX_LEN = 32;
  localparam int LEN_W   = 6;

  localparam logic [3:0] TLR = 4'd0, RTI = 4'd1, SDR = 4'd2, CDR = 4'd3, SHDR = 4'd4,
    E1DR = 4'd5, PDR = 4'd6, E2DR = 4'd7, UDR = 4'd8, SIR = 4'd9, CIR = 4'd10,
    SHIR = 4'd11, E1IR = 4'd12, PIR = 4'd13, E2IR = 4'd14, UIR = 4'd15;

  logic               TCK = 1'b0;
  logic               TRST = 1'b1;
  logic               cmd_valid = 1'b0;
  logic               cmd_ready;
  logic [1:0]         cmd_type = 2'd0;
  logic [LEN_W-1:0]   cmd_len = '0;
  logic [MAX_LEN-1:0] cmd_data = '0;
  logic               TMS, TDI, TDO;
  logic               rsp_valid;
  logic [MAX_LEN-1:0] rsp_data;
  logic               rsp_err;

  int n_tests = 0;
  int n_fail  = 0;
  logic [3:0]  exp_stream[$];  // {TMS, TDI, rsp_valid, cmd_ready} per cycle
  logic [32:0] exp_rsp[$];     // {rsp_err, rsp_data}

  jtag_cmd_driver #(.MAX_LEN(MAX_LEN), .LEN_W(LEN_W)) dut (
    .TCK(TCK), .TRST(TRST), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_type(cmd_type), .cmd_len(cmd_len), .cmd_data(cmd_data),
    .TMS(TMS), .TDI(TDI), .TDO(TDO),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_err(rsp_err)
  );

  always #5 TCK = ~TCK;

  // TAP model: 3-bit IR (INTEST=100, reset value 001), 4-bit DR capturing 1010.
  logic [3:0] tap_state = TLR;
  logic [2:0] ir_sh = 3'b0, tap_ir = 3'b001;
  logic [3:0] dr_sh = 4'b0, tap_dr = 4'b0;

  function automatic logic [3:0] tap_next(input logic [3:0] s, input logic t);
    case (s)
      TLR:  return t ? TLR  : RTI;
      RTI:  return t ? SDR  : RTI;
      SDR:  return t ? SIR  : CDR;
      CDR:  return t ? E1DR : SHDR;
      SHDR: return t ? E1DR : SHDR;
      E1DR: return t ? UDR  : PDR;
      PDR:  return t ? E2DR : PDR;
      E2DR: return t ? UDR  : SHDR;
      UDR:  return t ? SDR  : RTI;
      SIR:  return t ? TLR  : CIR;
      CIR:  return t ? E1IR : SHIR;
      SHIR: return t ? E1IR : SHIR;
      E1IR: return t ? UIR  : PIR;
      PIR:  return t ? E2IR : PIR;
      E2IR: return t ? UIR  : SHIR;
      default: return t ? SDR : RTI;
    endcase
  endfunction

  assign TDO = (tap_state == SHDR) ? dr_sh[0] : (tap_state == SHIR) ? ir_sh[0] : 1'b0;

  always @(posedge TCK) begin
    if (TRST) begin
      tap_state <= TLR;
      tap_ir    <= 3'b001;
    end else begin
      tap_state <= tap_next(tap_state, TMS);
      case (tap_state)
        TLR:  tap_ir <= 3'b001;
        CDR:  dr_sh  <= 4'b1010;
        SHDR: dr_sh  <= {TDI, dr_sh[3:1]};
        UDR:  tap_dr <= dr_sh;
        CIR:  ir_sh  <= 3'b001;
        SHIR: ir_sh  <= {TDI, ir_sh[2:1]};
        UIR:  tap_ir <= ir_sh;
        default: ;
      endcase
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %0h required %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge TCK) begin : monitor
    logic [3:0]  e;
    logic [32:0] r;
    if (exp_stream.size() > 0) begin
      e = exp_stream.pop_front();
      chk("stream {tms,tdi,rsp_valid,cmd_ready}", {28'd0, TMS, TDI, rsp_valid, cmd_ready}, {28'd0, e});
    end
    if (rsp_valid === 1'b1) begin
      if (exp_rsp.size() == 0) begin
        chk("unexpected rsp_valid", {31'd0, rsp_valid}, 32'd0);
      end else begin
        r = exp_rsp.pop_front();
        chk("rsp_data", rsp_data, r[31:0]);
        chk("rsp_err", {31'd0, rsp_err}, {31'd0, r[32]});
      end
    end
  end

  task automatic push_seq(input string tms, input string tdi);
    for (int i = 0; i < tms.len(); i++)
      exp_stream.push_back({tms[i] == 8'h31, tdi[i] == 8'h31, 2'b00});
    exp_stream.push_back(4'b0011);
  endtask

  task automatic send_cmd(input logic [1:0] t, input int len, input logic [31:0] d,
                          input string tms, input string tdi, input logic [31:0] rdata, input logic rerr);
    int  waited = 0;
    bit  ok = 0;
    @(negedge TCK);
    cmd_valid = 1'b1;
    cmd_type  = t;
    cmd_len   = LEN_W'(len);
    cmd_data  = d;
    while (!ok && waited < 500) begin
      if (cmd_ready === 1'b1) ok = 1;
      else begin
        @(negedge TCK);
        waited++;
      end
    end
    if (!ok) begin
      chk("cmd accept timeout", {31'd0, cmd_ready}, 32'd1);
      cmd_valid = 1'b0;
      return;
    end
    @(posedge TCK);
    push_seq(tms, tdi);
    exp_rsp.push_back({rerr, rdata});
    #1 cmd_valid = 1'b0;
  endtask

  task automatic wait_done();
    int w = 0;
    while (exp_stream.size() > 0 && w < 300) begin
      @(negedge TCK);
      w++;
    end
    if (exp_stream.size() > 0) begin
      chk("completion timeout", exp_stream.size(), 32'd0);
      exp_stream.delete();
    end
  endtask

  task automatic do_reset();
    exp_stream.delete();
    exp_rsp.delete();
    TRST = 1'b1;
    @(posedge TCK);
    #1;
    push_seq("111110", "000000");
    exp_stream[$] = 4'b0001;  // INIT ends in plain IDLE: ready, no response
    @(negedge TCK);
    chk("reset rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("reset rsp_data", rsp_data, 32'd0);
    chk("reset rsp_err", {31'd0, rsp_err}, 32'd0);
    chk("reset TDI", {31'd0, TDI}, 32'd0);
    TRST = 1'b0;
    wait_done();
  endtask

  initial begin
    string t32;
    t32 = "100";
    for (int i = 0; i < 31; i++) t32 = {t32, "0"};
    t32 = {t32, "110"};

    do_reset();
    chk("tap idle after init", {28'd0, tap_state}, {28'd0, RTI});

    send_cmd(2'd1, 3, 32'b100, "110000110", "000000100", 32'h1, 1'b0);
    wait_done();
    chk("tap ir after IR scan", {29'd0, tap_ir}, 32'b100);

    send_cmd(2'd2, 4, 32'b0110, "100000110", "000011000", 32'hA, 1'b0);
    wait_done();
    chk("tap dr after DR scan", {28'd0, tap_dr}, 32'b0110);

    send_cmd(2'd2, 0, 32'hFFFF, "", "", 32'h0, 1'b1);
    wait_done();
    send_cmd(2'd2, MAX_LEN + 1, 32'h1234, "", "", 32'h0, 1'b1);
    wait_done();
    chk("tap idle after bad len", {28'd0, tap_state}, {28'd0, RTI});

    send_cmd(2'd0, 9, 32'h5, "111110", "000000", 32'h0, 1'b0);
    wait_done();
    chk("tap ir after RESET cmd", {29'd0, tap_ir}, 32'b001);
    chk("tap idle after RESET cmd", {28'd0, tap_state}, {28'd0, RTI});

    send_cmd(2'd3, 5, 32'h0, "00000", "00000", 32'h0, 1'b0);
    send_cmd(2'd2, 4, 32'b1001, "100000110", "000100100", 32'hA, 1'b0);
    wait_done();
    chk("tap dr after back-to-back", {28'd0, tap_dr}, 32'b1001);

    send_cmd(2'd3, 0, 32'h0, "", "", 32'h0, 1'b0);
    wait_done();

    send_cmd(2'd2, 32, 32'hDEADBEEF, t32,
             {"000", "11110111011111011011010101111011", "00"}, 32'hEADBEEFA, 1'b0);
    wait_done();
    chk("tap dr after 32-bit scan", {28'd0, tap_dr}, 32'hD);

    send_cmd(2'd2, 8, 32'hA5, "1000000000110", "0001010010100", 32'h0, 1'b0);
    repeat (5) @(negedge TCK);
    do_reset();
    chk("tap idle after abort", {28'd0, tap_state}, {28'd0, RTI});
    repeat (20) @(negedge TCK);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, actual running required done");
    $fatal(1, "watchdog");
  end
endmodule
